// File: rtl/cmp_result_monitor_if.sv
// Bundle of signals between the comparator side and the result monitor:
// sample strobe, one-hot comparator code, synchronous clear, and the
// tallies/status reported back by the monitor.
interface cmp_result_monitor_if #(
    parameter int COUNT_W = 8
);
    logic               clear;
    logic               cmp_valid;
    logic [2:0]         cmp_result;
    logic [COUNT_W-1:0] gt_count;
    logic [COUNT_W-1:0] eq_count;
    logic [COUNT_W-1:0] lt_count;
    logic [3:0]         run_cnt;
    logic               match;
    logic               error;
    logic [1:0]         state;

    // Driver side: issues samples and clear, observes status.
    modport master (
        output clear, cmp_valid, cmp_result,
        input  gt_count, eq_count, lt_count, run_cnt, match, error, state
    );

    // Monitor side: consumes samples and clear, produces status.
    modport slave (
        input  clear, cmp_valid, cmp_result,
        output gt_count, eq_count, lt_count, run_cnt, match, error, state
    );
endinterface

// File: rtl/cmp_result_monitor.sv
// Result monitor placed after a 4-bit magnitude comparator. Tallies
// greater/equal/less samples with saturation, tracks the current run of
// consecutive equal samples, raises match once RUN_LEN equals arrive in a
// row, and traps non-one-hot codes in a sticky FAULT state.
module cmp_result_monitor #(
    parameter int COUNT_W = 8,
    parameter int RUN_LEN = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cmp_result_monitor_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_TRACK  = 2'b01,
        ST_LOCKED = 2'b10,
        ST_FAULT  = 2'b11
    } state_t;

    localparam logic [3:0]         RUN_MAX = 4'(RUN_LEN);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;
    localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_run_cnt;
    logic [3:0] w_run_next;
    logic       r_match;
    logic       w_match_next;
    logic       r_error;
    logic       w_error_next;

    logic       w_legal;
    logic       w_live;
    logic       w_accept;
    logic       w_illegal;
    logic       w_is_eq;

    // Classify the incoming code: only the three one-hot patterns are legal.
    always_comb begin
        w_legal = 1'b0;
        case (bus.cmp_result)
            3'b100, 3'b010, 3'b001: w_legal = 1'b1;
            default:                w_legal = 1'b0;
        endcase
    end

    // A sample is only considered when not overridden by clear and the
    // monitor is not parked in FAULT.
    assign w_live    = bus.cmp_valid & ~bus.clear & (r_state != ST_FAULT);
    assign w_accept  = w_live & w_legal;
    assign w_illegal = w_live & ~w_legal;
    assign w_is_eq   = bus.cmp_result[1];

    // Next-state, run length and status flags.
    always_comb begin
        w_state_next = r_state;
        w_run_next   = r_run_cnt;
        w_match_next = r_match;
        w_error_next = r_error;

        if (bus.clear) begin
            w_state_next = ST_IDLE;
            w_run_next   = 4'd0;
            w_match_next = 1'b0;
            w_error_next = 1'b0;
        end else if (w_illegal) begin
            // Run length is frozen; only the flags change on fault entry.
            w_state_next = ST_FAULT;
            w_match_next = 1'b0;
            w_error_next = 1'b1;
        end else if (w_accept) begin
            if (w_is_eq) begin
                w_run_next = (r_run_cnt < RUN_MAX) ? r_run_cnt + 4'd1 : RUN_MAX;
            end else begin
                w_run_next = 4'd0;
            end

            case (r_state)
                ST_IDLE: begin
                    // RUN_LEN >= 2, so a single equal sample cannot lock.
                    w_state_next = ST_TRACK;
                end
                ST_TRACK: begin
                    if (w_is_eq && (r_run_cnt + 4'd1 == RUN_MAX)) begin
                        w_state_next = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (!w_is_eq) begin
                        w_state_next = ST_TRACK;
                    end
                end
                default: begin
                    w_state_next = r_state;
                end
            endcase

            w_match_next = (w_state_next == ST_LOCKED);
            w_error_next = 1'b0;
        end
    end

    // State and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_run_cnt <= 4'd0;
            r_match   <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_run_cnt <= w_run_next;
            r_match   <= w_match_next;
            r_error   <= w_error_next;
        end
    end

    // One saturating tally per code bit: bit 2 = greater, 1 = equal, 0 = less.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_tally
            logic [COUNT_W-1:0] r_cnt;
            logic [COUNT_W-1:0] w_cnt_next;

            // Increment on an accepted sample of this kind unless saturated.
            always_comb begin
                w_cnt_next = r_cnt;
                if (bus.clear) begin
                    w_cnt_next = '0;
                end else if (w_accept && bus.cmp_result[gi] && (r_cnt != CNT_MAX)) begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end

            // Tally register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= w_cnt_next;
                end
            end
        end
    endgenerate

    assign bus.gt_count = g_tally[2].r_cnt;
    assign bus.eq_count = g_tally[1].r_cnt;
    assign bus.lt_count = g_tally[0].r_cnt;
    assign bus.run_cnt  = r_run_cnt;
    assign bus.match    = r_match;
    assign bus.error    = r_error;
    assign bus.state    = r_state;

endmodule

// File: tb/tb_cmp_result_monitor.sv
// Self-checking bench for cmp_result_monitor: a reference model computes the
// expected outputs when each stimulus is driven, pushes them to a queue, and
// the entry is popped and compared once the DUT has registered the sample.
module tb_cmp_result_monitor;
    localparam int RUN = 3;

    logic clk;
    logic rst_n;

    cmp_result_monitor_if #(.COUNT_W(8)) bus ();
    cmp_result_monitor_if #(.COUNT_W(2)) bus2 ();

    cmp_result_monitor #(.COUNT_W(8), .RUN_LEN(RUN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    cmp_result_monitor #(.COUNT_W(2), .RUN_LEN(RUN)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] gt;
        logic [7:0] eq;
        logic [7:0] lt;
        logic [3:0] run;
        logic       match;
        logic       error;
        logic [1:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_mis = 0;

    // Reference model state
    logic [7:0] m_gt, m_eq, m_lt;
    logic [3:0] m_run;
    logic [1:0] m_st;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] cmp_code(input int a, input int b);
        if (a > b)       return 3'b100;
        else if (a == b) return 3'b010;
        else             return 3'b001;
    endfunction

    task automatic model_reset();
        m_gt = 0; m_eq = 0; m_lt = 0; m_run = 0; m_st = 2'b00;
    endtask

    task automatic model_step(input bit clr, input bit v, input logic [2:0] code);
        if (clr) begin
            model_reset();
        end else if (v && m_st != 2'b11) begin
            if (!(code == 3'b100 || code == 3'b010 || code == 3'b001)) begin
                m_st = 2'b11;
            end else begin
                if (code == 3'b100 && m_gt != 8'hFF) m_gt++;
                if (code == 3'b010 && m_eq != 8'hFF) m_eq++;
                if (code == 3'b001 && m_lt != 8'hFF) m_lt++;
                if (code == 3'b010) m_run = (m_run < RUN) ? m_run + 1 : 4'(RUN);
                else                m_run = 0;
                m_st = (code == 3'b010 && m_run == RUN) ? 2'b10 : 2'b01;
            end
        end
    endtask

    task automatic check_outputs(input exp_t e);
        chk("gt_count", bus.gt_count, e.gt);
        chk("eq_count", bus.eq_count, e.eq);
        chk("lt_count", bus.lt_count, e.lt);
        chk("run_cnt",  bus.run_cnt,  e.run);
        chk("match",    bus.match,    e.match);
        chk("error",    bus.error,    e.error);
        chk("state",    bus.state,    e.st);
    endtask

    // Drive one cycle of stimulus, predict, then compare after the edge.
    task automatic apply(input bit clr, input bit v, input logic [2:0] code);
        exp_t e;
        @(negedge clk);
        bus.clear      = clr;
        bus.cmp_valid  = v;
        bus.cmp_result = code;
        model_step(clr, v, code);
        e.gt = m_gt; e.eq = m_eq; e.lt = m_lt; e.run = m_run;
        e.match = (m_st == 2'b10); e.error = (m_st == 2'b11); e.st = m_st;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check_outputs(e);
        end
        $display("txn clr=%0d v=%0d code=%b -> st=%0d gt=%0d eq=%0d lt=%0d run=%0d m=%0d e=%0d",
                 clr, v, code, bus.state, bus.gt_count, bus.eq_count, bus.lt_count,
                 bus.run_cnt, bus.match, bus.error);
        bus.clear     = 1'b0;
        bus.cmp_valid = 1'b0;
    endtask

    task automatic sample(input int a, input int b);
        apply(1'b0, 1'b1, cmp_code(a, b));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_run[4];
        int exp_sat[4];
        logic [2:0] bad_codes[4];
        exp_run = '{1, 2, 0, 1};
        exp_sat = '{1, 2, 3, 3};
        bad_codes = '{3'b000, 3'b101, 3'b110, 3'b111};

        rst_n = 1'b0;
        bus.clear = 0; bus.cmp_valid = 0; bus.cmp_result = 3'b000;
        bus2.clear = 0; bus2.cmp_valid = 0; bus2.cmp_result = 3'b000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", bus.state, 0);
        chk("rst_gt", bus.gt_count, 0);
        chk("rst_match", bus.match, 0);
        chk("rst_error", bus.error, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // One of each outcome, with idle gaps
        sample(15, 0);  apply(0, 0, 3'b000);
        sample(5, 5);   apply(0, 0, 3'b010);
        sample(10, 15); apply(0, 0, 3'b100);
        chk("mix_gt", bus.gt_count, 1);
        chk("mix_eq", bus.eq_count, 1);
        chk("mix_lt", bus.lt_count, 1);
        chk("mix_run", bus.run_cnt, 0);
        chk("mix_state", bus.state, 1);

        // Lock on three consecutive equals, stay locked, then unlock
        sample(5, 5); sample(2, 2); sample(7, 7);
        chk("lock_state", bus.state, 2);
        chk("lock_match", bus.match, 1);
        chk("lock_run", bus.run_cnt, 3);
        chk("lock_eq", bus.eq_count, 4);
        sample(9, 9);
        chk("lock_eq2", bus.eq_count, 5);
        chk("lock_run2", bus.run_cnt, 3);
        sample(10, 15);
        chk("unlock_state", bus.state, 1);
        chk("unlock_match", bus.match, 0);
        chk("unlock_run", bus.run_cnt, 0);

        // Broken run never locks
        for (int i = 0; i < 4; i++) begin
            if (i == 2) sample(15, 0);
            else        sample(3, 3);
            chk("brk_run", bus.run_cnt, exp_run[i]);
            chk("brk_match", bus.match, 0);
        end

        // Illegal code traps in FAULT; later samples ignored; clear recovers
        apply(0, 1, 3'b011);
        chk("flt_state", bus.state, 3);
        chk("flt_error", bus.error, 1);
        sample(15, 0); sample(4, 4);
        chk("flt_gt", bus.gt_count, 2);
        apply(1, 0, 3'b000);
        chk("clr_state", bus.state, 0);
        chk("clr_eq", bus.eq_count, 0);
        apply(1, 1, 3'b100);
        chk("clrv_gt", bus.gt_count, 0);

        // Remaining illegal codes, each from TRACK, then cleared
        for (int i = 0; i < 4; i++) begin
            sample(1, 2);
            apply(0, 1, bad_codes[i]);
            chk("bad_error", bus.error, 1);
            apply(1, 0, 3'b000);
        end

        // Fault entered from LOCKED forces match low
        sample(1, 1); sample(1, 1); sample(1, 1);
        apply(0, 1, 3'b110);
        chk("lkflt_match", bus.match, 0);
        apply(1, 0, 3'b000);

        // Saturation on the 2-bit instance
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus2.cmp_valid = 1; bus2.cmp_result = cmp_code(15, 0);
            @(posedge clk);
            #1;
            chk("sat_gt", bus2.gt_count, exp_sat[i]);
            $display("txn sat sample %0d -> gt=%0d", i, bus2.gt_count);
            bus2.cmp_valid = 0;
        end

        // Asynchronous reset mid-run
        sample(6, 6); sample(6, 6);
        chk("pre_rst_run", bus.run_cnt, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_run", bus.run_cnt, 0);
        chk("arst_state", bus.state, 0);
        chk("arst_eq", bus.eq_count, 0);
        chk("arst_gt", bus.gt_count, 0);
        chk("arst_sat", bus2.gt_count, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        sample(8, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
